core_dispatcher: RTL and testbench

//  Moves events between the central event queue and the NUM_CORE processing cores.

---
 rtl/core_dispatcher.sv | 175 +++++++++++++++++
 tb/tb_core_dispatcher.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/core_dispatcher.sv
// rtl/core_dispatcher.sv - moves events between the event queue and the core array
// Pops queue-head events to idle cores, returns completions to the queue, strobes the monitor.
module core_dispatcher #(
  parameter int NUM_CORE = 4,
  parameter int NUM_LP   = 8,
  parameter int TIME_WID = 16,
  parameter int MSG_WID  = 32,
  localparam int NB_CORE = $clog2(NUM_CORE),
  localparam int CNT_W   = $clog2(NUM_CORE + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        q_deq_vld,
  input  logic [MSG_WID-1:0]          q_deq_msg,
  output logic                        q_deq_rdy,
  output logic                        q_enq_vld,
  output logic [MSG_WID-1:0]          q_enq_msg,
  input  logic                        q_enq_rdy,
  output logic [NUM_CORE-1:0]         core_req_vld,
  output logic [MSG_WID-1:0]          core_msg,
  input  logic [NUM_CORE-1:0]         core_done_vld,
  input  logic [NUM_CORE*MSG_WID-1:0] core_done_msg,
  output logic [NUM_CORE-1:0]         core_done_ack,
  output logic                        mon_sent_vld,
  output logic                        mon_rcv_vld,
  output logic [NB_CORE-1:0]          mon_core_id,
  output logic [MSG_WID-1:0]          mon_msg,
  output logic [CNT_W-1:0]            active_cnt,
  output logic                        err_spurious
);

  localparam int NB_LP = $clog2(NUM_LP);
  // Latched-message width collapses if the time + LP fields overflow the message.
  localparam int SEL_MSG_W = (TIME_WID + NB_LP <= MSG_WID) ? MSG_WID : 1;

  typedef enum logic [1:0] {IDLE, SEND, RECV} state_t;

  state_t                 state, state_nxt;
  logic [NUM_CORE-1:0]    busy, busy_nxt;
  logic [NB_CORE-1:0]     sel_id, sel_id_nxt;
  logic [NB_CORE-1:0]     rr_ptr, rr_ptr_nxt;
  logic [SEL_MSG_W-1:0]   sel_msg, sel_msg_nxt;
  logic [CNT_W-1:0]       cnt_nxt;

  logic [NUM_CORE-1:0]    pend;
  logic [NUM_CORE-1:0]    idle;
  logic                   idle_any;
  logic [NB_CORE-1:0]     rr_id;
  logic [NB_CORE-1:0]     idle_id;
  logic [NUM_CORE-1:0]    sel_onehot;
  logic [MSG_WID-1:0]     done_msg [NUM_CORE];

  for (genvar k = 0; k < NUM_CORE; k++) begin : g_split
    assign done_msg[k] = core_done_msg[k*MSG_WID +: MSG_WID];
  end

  assign pend       = core_done_vld & busy;
  assign idle       = ~busy;
  assign idle_any   = |idle;
  assign sel_onehot = {{(NUM_CORE-1){1'b0}}, 1'b1} << sel_id;

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    rr_id = rr_ptr;
    for (int i = NUM_CORE - 1; i >= 0; i--) begin
      if (pend[rr_ptr + NB_CORE'(i)]) rr_id = rr_ptr + NB_CORE'(i);
    end
  end

  always_comb begin
    idle_id = '0;
    for (int i = NUM_CORE - 1; i >= 0; i--) begin
      if (idle[i]) idle_id = NB_CORE'(i);
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= '0;
      sel_id       <= '0;
      sel_msg      <= '0;
      rr_ptr       <= '0;
      active_cnt   <= '0;
      err_spurious <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= busy_nxt;
      sel_id       <= sel_id_nxt;
      sel_msg      <= sel_msg_nxt;
      rr_ptr       <= rr_ptr_nxt;
      active_cnt   <= cnt_nxt;
      err_spurious <= err_spurious | (|(core_done_vld & ~busy));
    end
  end

  // Completions take priority over dispatch so busy cores always drain.
  always_comb begin
    state_nxt   = state;
    busy_nxt    = busy;
    sel_id_nxt  = sel_id;
    sel_msg_nxt = sel_msg;
    rr_ptr_nxt  = rr_ptr;
    case (state)
      IDLE: begin
        if (|pend) begin
          sel_id_nxt  = rr_id;
          sel_msg_nxt = SEL_MSG_W'(done_msg[rr_id]);
          state_nxt   = RECV;
        end else if (q_deq_vld && idle_any) begin
          sel_id_nxt  = idle_id;
          sel_msg_nxt = SEL_MSG_W'(q_deq_msg);
          state_nxt   = SEND;
        end
      end
      SEND: begin
        busy_nxt[sel_id] = 1'b1;
        state_nxt        = IDLE;
      end
      RECV: begin
        if (q_enq_rdy) begin
          busy_nxt[sel_id] = 1'b0;
          rr_ptr_nxt       = sel_id + 1'b1;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset masks the decode so an in-flight pop or ack is dropped.
  always_comb begin
    q_deq_rdy     = 1'b0;
    q_enq_vld     = 1'b0;
    q_enq_msg     = '0;
    core_req_vld  = '0;
    core_msg      = '0;
    core_done_ack = '0;
    mon_sent_vld  = 1'b0;
    mon_rcv_vld   = 1'b0;
    mon_core_id   = '0;
    mon_msg       = '0;
    if (!reset) begin
      case (state)
        SEND: begin
          q_deq_rdy    = 1'b1;
          core_req_vld = sel_onehot;
          core_msg     = MSG_WID'(sel_msg);
          mon_sent_vld = 1'b1;
          mon_core_id  = sel_id;
          mon_msg      = MSG_WID'(sel_msg);
        end
        RECV: begin
          q_enq_vld = 1'b1;
          q_enq_msg = MSG_WID'(sel_msg);
          if (q_enq_rdy) begin
            core_done_ack = sel_onehot;
            mon_rcv_vld   = 1'b1;
            mon_core_id   = sel_id;
            mon_msg       = MSG_WID'(sel_msg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_dispatcher.sv
// tb/tb_core_dispatcher.sv - directed self-checking bench for core_dispatcher
module tb_core_dispatcher;

  logic          clk = 1'b0;
  logic          reset;
  logic          q_deq_vld;
  logic [31:0]   q_deq_msg;
  logic          q_deq_rdy;
  logic          q_enq_vld;
  logic [31:0]   q_enq_msg;
  logic          q_enq_rdy;
  logic [3:0]    core_req_vld;
  logic [31:0]   core_msg;
  logic [3:0]    core_done_vld;
  logic [127:0]  core_done_msg;
  logic [3:0]    core_done_ack;
  logic          mon_sent_vld;
  logic          mon_rcv_vld;
  logic [1:0]    mon_core_id;
  logic [31:0]   mon_msg;
  logic [2:0]    active_cnt;
  logic          err_spurious;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_dispatcher #(.NUM_CORE(4), .NUM_LP(8), .TIME_WID(16), .MSG_WID(32)) dut (
    .clk(clk), .reset(reset),
    .q_deq_vld(q_deq_vld), .q_deq_msg(q_deq_msg), .q_deq_rdy(q_deq_rdy),
    .q_enq_vld(q_enq_vld), .q_enq_msg(q_enq_msg), .q_enq_rdy(q_enq_rdy),
    .core_req_vld(core_req_vld), .core_msg(core_msg),
    .core_done_vld(core_done_vld), .core_done_msg(core_done_msg), .core_done_ack(core_done_ack),
    .mon_sent_vld(mon_sent_vld), .mon_rcv_vld(mon_rcv_vld),
    .mon_core_id(mon_core_id), .mon_msg(mon_msg),
    .active_cnt(active_cnt), .err_spurious(err_spurious)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; q_deq_vld = 1'b1; q_deq_msg = 32'hdead_beef; q_enq_rdy = 1'b1;
    core_done_vld = 4'b1111; core_done_msg = {4{32'h1234_5678}};
    repeat (3) cyc();
    checks++; if (q_deq_rdy !== 1'b0) begin failures++; $display("FAIL t1_q_deq_rdy got %0h want 0", q_deq_rdy); end
    checks++; if (core_done_ack !== 4'b0000) begin failures++; $display("FAIL t1_ack got %b want 0000", core_done_ack); end
    checks++; if ({q_enq_vld, mon_sent_vld, mon_rcv_vld, core_req_vld, mon_core_id, mon_msg} !== '0) begin failures++; $display("FAIL t1_outputs got nonzero want 0"); end
    checks++; if (active_cnt !== 3'd0) begin failures++; $display("FAIL t1_active_cnt got %0d want 0", active_cnt); end
    checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL t1_err got %0b want 0", err_spurious); end
    reset = 1'b0; q_deq_vld = 1'b0; core_done_vld = 4'b0000;
    cyc();
    checks++; if (q_deq_rdy !== 1'b0 || err_spurious !== 1'b0) begin failures++; $display("FAIL t1_release got rdy=%0b err=%0b want 0 0", q_deq_rdy, err_spurious); end
  endtask

  task automatic test_dispatch();
    q_deq_vld = 1'b1; q_deq_msg = 32'h0003_0010;
    #1;
    checks++; if (q_deq_rdy !== 1'b0) begin failures++; $display("FAIL t2_cycle1_rdy got %0b want 0", q_deq_rdy); end
    cyc();
    checks++; if (q_deq_rdy !== 1'b1) begin failures++; $display("FAIL t2_pop got %0b want 1", q_deq_rdy); end
    checks++; if (core_req_vld !== 4'b0001) begin failures++; $display("FAIL t2_req got %b want 0001", core_req_vld); end
    checks++; if (mon_sent_vld !== 1'b1 || mon_rcv_vld !== 1'b0) begin failures++; $display("FAIL t2_strobe got sent=%0b rcv=%0b want 1 0", mon_sent_vld, mon_rcv_vld); end
    checks++; if (mon_core_id !== 2'd0 || mon_msg !== 32'h0003_0010) begin failures++; $display("FAIL t2_mon got id=%0d msg=%h want 0 00030010", mon_core_id, mon_msg); end
    checks++; if (core_msg !== 32'h0003_0010) begin failures++; $display("FAIL t2_core_msg got %h want 00030010", core_msg); end
    q_deq_msg = 32'h0005_0020;
    cyc();
    checks++; if (active_cnt !== 3'd1) begin failures++; $display("FAIL t2_cnt1 got %0d want 1", active_cnt); end
    checks++; if (mon_sent_vld !== 1'b0 || mon_core_id !== 2'd0 || mon_msg !== 32'h0) begin failures++; $display("FAIL t2_gap got sent=%0b id=%0d msg=%h want 0 0 0", mon_sent_vld, mon_core_id, mon_msg); end
    cyc();
    checks++; if (core_req_vld !== 4'b0010 || mon_core_id !== 2'd1 || mon_msg !== 32'h0005_0020) begin failures++; $display("FAIL t2_second got req=%b id=%0d msg=%h want 0010 1 00050020", core_req_vld, mon_core_id, mon_msg); end
    q_deq_vld = 1'b0;
    cyc();
    checks++; if (active_cnt !== 3'd2) begin failures++; $display("FAIL t2_cnt2 got %0d want 2", active_cnt); end
  endtask

  task automatic test_recv();
    q_deq_vld = 1'b1; q_deq_msg = 32'h0007_0030;
    cyc();
    checks++; if (core_req_vld !== 4'b0100) begin failures++; $display("FAIL t3_fill got %b want 0100", core_req_vld); end
    q_deq_vld = 1'b0;
    cyc();
    checks++; if (active_cnt !== 3'd3) begin failures++; $display("FAIL t3_cnt3 got %0d want 3", active_cnt); end
    q_enq_rdy = 1'b1;
    core_done_msg[0 +: 32] = 32'h0103_0011; core_done_vld = 4'b0001;
    cyc();
    checks++; if (core_done_ack !== 4'b0001 || mon_rcv_vld !== 1'b1 || q_enq_msg !== 32'h0103_0011) begin failures++; $display("FAIL t3_core0 got ack=%b rcv=%0b msg=%h want 0001 1 01030011", core_done_ack, mon_rcv_vld, q_enq_msg); end
    cyc();
    core_done_vld = 4'b0000;
    checks++; if (active_cnt !== 3'd2) begin failures++; $display("FAIL t3_cnt_after0 got %0d want 2", active_cnt); end
    core_done_msg[32 +: 32] = 32'h0203_0012; core_done_msg[64 +: 32] = 32'h0303_0013;
    core_done_vld = 4'b0110;
    cyc();
    checks++; if (core_done_ack !== 4'b0010 || mon_core_id !== 2'd1 || mon_msg !== 32'h0203_0012) begin failures++; $display("FAIL t3_first got ack=%b id=%0d msg=%h want 0010 1 02030012", core_done_ack, mon_core_id, mon_msg); end
    checks++; if (mon_rcv_vld !== 1'b1 || mon_sent_vld !== 1'b0) begin failures++; $display("FAIL t3_first_strobe got rcv=%0b sent=%0b want 1 0", mon_rcv_vld, mon_sent_vld); end
    cyc();
    core_done_vld[1] = 1'b0;
    #1;
    checks++; if (mon_rcv_vld !== 1'b0 || core_done_ack !== 4'b0000) begin failures++; $display("FAIL t3_gap got rcv=%0b ack=%b want 0 0000", mon_rcv_vld, core_done_ack); end
    cyc();
    checks++; if (core_done_ack !== 4'b0100 || mon_core_id !== 2'd2 || mon_msg !== 32'h0303_0013 || mon_sent_vld !== 1'b0) begin failures++; $display("FAIL t3_second got ack=%b id=%0d msg=%h sent=%0b want 0100 2 03030013 0", core_done_ack, mon_core_id, mon_msg, mon_sent_vld); end
    cyc();
    core_done_vld = 4'b0000;
    checks++; if (active_cnt !== 3'd0 || err_spurious !== 1'b0) begin failures++; $display("FAIL t3_drained got cnt=%0d err=%0b want 0 0", active_cnt, err_spurious); end
  endtask

  task automatic test_full_and_backpressure();
    logic [3:0] exp_oh;
    q_deq_vld = 1'b1;
    for (int k = 0; k < 4; k++) begin
      q_deq_msg = 32'h0010_0000 + 32'(k);
      exp_oh = 4'b0001 << k;
      cyc();
      checks++; if (core_req_vld !== exp_oh || core_msg !== 32'h0010_0000 + 32'(k)) begin failures++; $display("FAIL t5_fill%0d got req=%b msg=%h want %b", k, core_req_vld, core_msg, exp_oh); end
      cyc();
    end
    q_deq_msg = 32'h0004_0099;
    checks++; if (active_cnt !== 3'd4) begin failures++; $display("FAIL t5_cnt4 got %0d want 4", active_cnt); end
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (q_deq_rdy !== 1'b0) begin failures++; $display("FAIL t5_no_pop%0d got %0b want 0", i, q_deq_rdy); end
      cyc();
    end
    q_enq_rdy = 1'b0;
    core_done_msg[64 +: 32] = 32'h0503_0015; core_done_vld = 4'b0100;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (q_enq_vld !== 1'b1 || q_enq_msg !== 32'h0503_0015) begin failures++; $display("FAIL t4_hold%0d got vld=%0b msg=%h want 1 05030015", i, q_enq_vld, q_enq_msg); end
      checks++; if (core_done_ack !== 4'b0000 || q_deq_rdy !== 1'b0 || mon_rcv_vld !== 1'b0) begin failures++; $display("FAIL t4_quiet%0d got ack=%b pop=%0b rcv=%0b want 0000 0 0", i, core_done_ack, q_deq_rdy, mon_rcv_vld); end
      cyc();
    end
    q_enq_rdy = 1'b1;
    #1;
    checks++; if (core_done_ack !== 4'b0100 || mon_rcv_vld !== 1'b1 || mon_core_id !== 2'd2 || mon_msg !== 32'h0503_0015) begin failures++; $display("FAIL t4_release got ack=%b rcv=%0b id=%0d msg=%h want 0100 1 2 05030015", core_done_ack, mon_rcv_vld, mon_core_id, mon_msg); end
    cyc();
    core_done_vld = 4'b0000;
    cyc();
    checks++; if (core_req_vld !== 4'b0100 || mon_msg !== 32'h0004_0099) begin failures++; $display("FAIL t5_refill got req=%b msg=%h want 0100 00040099", core_req_vld, mon_msg); end
    q_deq_vld = 1'b0;
    cyc();
    checks++; if (active_cnt !== 3'd4) begin failures++; $display("FAIL t5_cnt_full got %0d want 4", active_cnt); end
  endtask

  task automatic test_round_robin();
    core_done_msg[0 +: 32] = 32'h0603_0016; core_done_msg[96 +: 32] = 32'h0703_0017;
    core_done_vld = 4'b1001;
    cyc();
    checks++; if (core_done_ack !== 4'b1000 || mon_core_id !== 2'd3 || mon_msg !== 32'h0703_0017) begin failures++; $display("FAIL rr_first got ack=%b id=%0d msg=%h want 1000 3 07030017", core_done_ack, mon_core_id, mon_msg); end
    cyc();
    core_done_vld[3] = 1'b0;
    cyc();
    checks++; if (core_done_ack !== 4'b0001 || mon_core_id !== 2'd0 || mon_msg !== 32'h0603_0016) begin failures++; $display("FAIL rr_second got ack=%b id=%0d msg=%h want 0001 0 06030016", core_done_ack, mon_core_id, mon_msg); end
    cyc();
    core_done_vld = 4'b0000;
    checks++; if (active_cnt !== 3'd2) begin failures++; $display("FAIL rr_cnt got %0d want 2", active_cnt); end
  endtask

  task automatic test_spurious_and_reset();
    core_done_vld = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (core_done_ack !== 4'b0000 || q_enq_vld !== 1'b0) begin failures++; $display("FAIL t6_ignore%0d got ack=%b enq=%0b want 0000 0", i, core_done_ack, q_enq_vld); end
    end
    checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL t6_err_set got %0b want 1", err_spurious); end
    core_done_vld = 4'b0000;
    cyc();
    checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL t6_err_sticky got %0b want 1", err_spurious); end
    q_enq_rdy = 1'b0;
    core_done_msg[32 +: 32] = 32'h0803_0018; core_done_vld = 4'b0010;
    cyc();
    checks++; if (q_enq_vld !== 1'b1 || q_enq_msg !== 32'h0803_0018) begin failures++; $display("FAIL t6_in_recv got vld=%0b msg=%h want 1 08030018", q_enq_vld, q_enq_msg); end
    reset = 1'b1; q_enq_rdy = 1'b1;
    #1;
    checks++; if (core_done_ack !== 4'b0000 || mon_rcv_vld !== 1'b0 || q_enq_vld !== 1'b0) begin failures++; $display("FAIL t6_reset_ack got ack=%b rcv=%0b enq=%0b want 0000 0 0", core_done_ack, mon_rcv_vld, q_enq_vld); end
    cyc();
    checks++; if (active_cnt !== 3'd0 || err_spurious !== 1'b0) begin failures++; $display("FAIL t6_reset_regs got cnt=%0d err=%0b want 0 0", active_cnt, err_spurious); end
    reset = 1'b0; core_done_vld = 4'b0000;
    cyc();
    checks++; if (q_enq_vld !== 1'b0 || core_done_ack !== 4'b0000 || active_cnt !== 3'd0) begin failures++; $display("FAIL t6_idle got enq=%0b ack=%b cnt=%0d want 0 0000 0", q_enq_vld, core_done_ack, active_cnt); end
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_recv();
    test_full_and_backpressure();
    test_round_robin();
    test_spurious_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
